// File: rtl/pif_arb_pkg.sv
// -----------------------------------------------------------------------------
// pif_arb_pkg
// Shared constants and types for the PIF RAM arbiter.
//   NUM_REQ    : default requester count (0 = SI DMA, 1 = joybus, 2 = boot seq)
//   LEN_W      : default burst-length field width (burst = len+1 words)
//   PIF_ADDR_W : PIF RAM word address width
//   PIF_DATA_W : PIF RAM data width
//   arb_state_e: arbiter FSM states
// -----------------------------------------------------------------------------
package pif_arb_pkg;

  localparam int NUM_REQ    = 3;
  localparam int LEN_W      = 4;
  localparam int PIF_ADDR_W = 9;
  localparam int PIF_DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of a requester index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pif_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// pif_ram_arbiter_if
// Bundles the requester-side burst handshake and the PIF RAM 32-bit port.
//   req/we/addr/len/wdata : per-requester burst request (flattened vectors)
//   ack/done/rvalid/rdata : per-requester responses (one-hot)
//   ram_address/ram_wren/ram_data/ram_q : PIF RAM 32-bit port
// Modports: slave = arbiter, master = requesters plus RAM.
//
// Handshake: a requester raises req[i] with we/addr/len stable and keeps it high
// until done[i]. Every cycle ack[i] is high one word is transferred and the
// requester advances wdata on the following cycle. Dropping req[i] before done
// aborts the burst. For reads, rvalid[i]/rdata arrive one cycle after each ack.
// -----------------------------------------------------------------------------
interface pif_ram_arbiter_if #(
  parameter int NUM_REQ = pif_arb_pkg::NUM_REQ,
  parameter int LEN_W   = pif_arb_pkg::LEN_W
);

  localparam int AW = pif_arb_pkg::PIF_ADDR_W;
  localparam int DW = pif_arb_pkg::PIF_DATA_W;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       we;
  logic [NUM_REQ*AW-1:0]    addr;
  logic [NUM_REQ*LEN_W-1:0] len;
  logic [NUM_REQ*DW-1:0]    wdata;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       rvalid;
  logic [DW-1:0]            rdata;
  logic [AW-1:0]            ram_address;
  logic                     ram_wren;
  logic [DW-1:0]            ram_data;
  logic [DW-1:0]            ram_q;

  modport slave (
    input  req, we, addr, len, wdata, ram_q,
    output ack, done, rvalid, rdata, ram_address, ram_wren, ram_data
  );

  modport master (
    output req, we, addr, len, wdata, ram_q,
    input  ack, done, rvalid, rdata, ram_address, ram_wren, ram_data
  );

endinterface

// File: rtl/pif_rr_picker.sv
// -----------------------------------------------------------------------------
// pif_rr_picker
// Combinational round-robin selector. Priority starts at (last_owner+1) mod
// NUM_REQ and wraps around.
//   req_i        : request vector
//   last_owner_i : index of the previous burst owner
//   grant_o      : one-hot winner (all zero when no request)
//   idx_o        : index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module pif_rr_picker
  import pif_arb_pkg::*;
#(
  parameter int NUM_REQ = pif_arb_pkg::NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % NUM_REQ);
  endfunction

  // Scan from lowest priority to highest so the highest-priority hit is the
  // last write and wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_i[slot(last_owner_i, k)]) begin
        grant_o                         = '0;
        grant_o[slot(last_owner_i, k)]  = 1'b1;
        idx_o                           = slot(last_owner_i, k);
      end
    end
  end

endmodule

// File: rtl/pif_ram_arbiter.sv
// -----------------------------------------------------------------------------
// pif_ram_arbiter
// Round-robin burst arbiter in front of the PIF RAM 32-bit port.
//   clk     : clock
//   reset   : synchronous, active-high reset
//   bus     : requester handshake + RAM port (slave modport)
//   state_o : current FSM state, for observation
// One RAM word per cycle while a burst owns the port; each burst is followed
// by at least one IDLE cycle in which the next owner is chosen.
// -----------------------------------------------------------------------------
module pif_ram_arbiter
  import pif_arb_pkg::*;
#(
  parameter int NUM_REQ = pif_arb_pkg::NUM_REQ,
  parameter int LEN_W   = pif_arb_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  pif_ram_arbiter_if.slave bus,
  output arb_state_e       state_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        owner_q, last_owner_q, rv_owner_q, pick_idx;
  logic [NUM_REQ-1:0]      pick_grant;
  logic                    we_q, rvalid_q;
  logic [PIF_ADDR_W-1:0]   cnt_q, hold_addr_q;
  logic [LEN_W-1:0]        rem_q;
  logic                    start, access, abort, last;

  pif_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i        (bus.req),
    .last_owner_i (last_owner_q),
    .grant_o      (pick_grant),
    .idx_o        (pick_idx)
  );

  // Next state and per-cycle actions. Reset suppresses every action in the
  // cycle it is asserted, so an abandoned burst produces no ack/done/rvalid.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    access  = 1'b0;
    abort   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          start   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!bus.req[owner_q]) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          access = 1'b1;
          if (rem_q == '0) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d = IDLE;
      start   = 1'b0;
      access  = 1'b0;
      abort   = 1'b0;
      last    = 1'b0;
    end
  end

  always_comb begin
    bus.ack                 = '0;
    bus.done                = '0;
    bus.rvalid              = '0;
    bus.ack[owner_q]        = access;
    bus.done[owner_q]       = last;
    bus.rvalid[rv_owner_q]  = rvalid_q && !reset;
    bus.rdata               = (rvalid_q && !reset) ? bus.ram_q : '0;
    bus.ram_wren            = access && we_q;
    // Address is held at the last issued word whenever no access happens.
    bus.ram_address         = access ? cnt_q : hold_addr_q;
    bus.ram_data            = bus.wdata[owner_q*PIF_DATA_W +: PIF_DATA_W];
  end

  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      hold_addr_q  <= '0;
      rem_q        <= '0;
      rvalid_q     <= 1'b0;
      rv_owner_q   <= '0;
    end else begin
      state_q  <= state_d;
      // RAM read data is registered, so rvalid trails the read access by one.
      rvalid_q <= access && !we_q;
      if (access) rv_owner_q <= owner_q;
      if (start) begin
        owner_q <= pick_idx;
        we_q    <= |(bus.we & pick_grant);
        cnt_q   <= bus.addr[pick_idx*PIF_ADDR_W +: PIF_ADDR_W];
        rem_q   <= bus.len[pick_idx*LEN_W +: LEN_W];
      end
      if (access) begin
        cnt_q       <= cnt_q + 1'b1;   // 511 wraps to 0
        rem_q       <= rem_q - 1'b1;
        hold_addr_q <= cnt_q;
      end
      if (last || abort) last_owner_q <= owner_q;
    end
  end

endmodule

// File: tb/tb_pif_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pif_ram_arbiter
// Directed bench for pif_ram_arbiter with a registered-read RAM model.
// -----------------------------------------------------------------------------
module tb_pif_ram_arbiter;
  import pif_arb_pkg::*;

  localparam int NR = 3;
  localparam int LW = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       load_mem;
  arb_state_e dbg_state;

  always #5 clk = ~clk;

  pif_ram_arbiter_if #(.NUM_REQ(NR), .LEN_W(LW)) bus ();

  pif_ram_arbiter #(.NUM_REQ(NR), .LEN_W(LW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- RAM model (registered read) ----------------
  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];

  function automatic logic [31:0] pat(input logic [8:0] a);
    return 32'h5A5A_0000 | {23'd0, a};
  endfunction

  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 512; k++) mem[k] <= pat(9'(k));
    end else if (bus.ram_wren) begin
      mem[bus.ram_address] <= bus.ram_data;
    end
    bus.ram_q <= mem[bus.ram_address];
  end

  // ---------------- scoreboard state ----------------
  int           n_checks, n_fail, cyc;
  logic [31:0]  exp_q [$];        // expected ack addresses, in order
  logic [31:0]  exp_wdata_q [$];  // expected write words, in order
  logic [NR-1:0] ack_log [$];
  logic [NR-1:0] pend_rv;
  logic [31:0]  pend_rdata;
  int           ack_cnt [NR], done_cnt [NR], rv_cnt [NR];
  int           first_ack_cyc [NR], done_cyc [NR], stop_after [NR];
  logic [NR-1:0] hold;
  logic [31:0]  wr_words [4];
  int           widx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    exp_q.delete();
    exp_wdata_q.delete();
    ack_log.delete();
    hold = '0;
    for (int i = 0; i < NR; i++) begin
      ack_cnt[i] = 0; done_cnt[i] = 0; rv_cnt[i] = 0;
      first_ack_cyc[i] = 0; done_cyc[i] = 0; stop_after[i] = 0;
    end
  endtask

  task automatic start_req(input int i, input logic w, input logic [8:0] a, input logic [3:0] l);
    bus.we[i]           = w;
    bus.addr[i*9 +: 9]  = a;
    bus.len[i*LW +: LW] = l;
    bus.req[i]          = 1'b1;
  endtask

  // One clock: sample outputs on the falling edge, then update requester
  // inputs just after the rising edge.
  task automatic cycle();
    logic [NR-1:0] exp_rv, new_pend, ack_s, done_s;
    logic [31:0]   ea, ed;
    @(negedge clk);
    cyc++;
    exp_rv = reset ? '0 : pend_rv;
    if ((bus.rvalid | exp_rv) != '0) begin
      check("rvalid_vec", 32'(bus.rvalid), 32'(exp_rv));
      if (bus.rvalid == exp_rv) check("rdata", bus.rdata, pend_rdata);
    end
    ack_s    = bus.ack;
    done_s   = bus.done;
    new_pend = '0;
    ack_log.push_back(bus.ack);
    if (bus.ack != '0) check("ack_onehot", 32'($countones(bus.ack)), 32'd1);
    if (bus.ack == '0 && bus.ram_wren) check("wren_without_ack", 32'(bus.ram_wren), 32'd0);
    for (int i = 0; i < NR; i++) begin
      if (bus.rvalid[i]) rv_cnt[i]++;
      if (bus.ack[i]) begin
        ack_cnt[i]++;
        if (ack_cnt[i] == 1) first_ack_cyc[i] = cyc;
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 32'(bus.ack), 32'd0);
        end else begin
          ea = exp_q.pop_front();
          check("ram_address", 32'(bus.ram_address), ea);
          check("ram_wren", 32'(bus.ram_wren), 32'(bus.we[i]));
          if (bus.we[i]) begin
            if (exp_wdata_q.size() == 0) begin
              check("wdata_unexpected", 32'(bus.ram_wren), 32'd0);
            end else begin
              ed = exp_wdata_q.pop_front();
              check("ram_data", bus.ram_data, ed);
              ref_mem[ea[8:0]] = ed;
            end
          end else begin
            new_pend[i] = 1'b1;
            pend_rdata  = ref_mem[ea[8:0]];
          end
        end
      end
      if (bus.done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        check("done_with_ack", 32'(bus.ack[i]), 32'd1);
      end
    end
    pend_rv = new_pend;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ack_s[i] && i == 0) begin
        widx++;
        bus.wdata[31:0] = (widx < 4) ? wr_words[widx] : 32'd0;
      end
      if (done_s[i] && !hold[i]) bus.req[i] = 1'b0;
      if (stop_after[i] != 0 && ack_s[i] && ack_cnt[i] == stop_after[i]) bus.req[i] = 1'b0;
    end
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while ((bus.req != '0 || pend_rv != '0) && n < max_cyc) begin
      cycle();
      n++;
    end
    if (n >= max_cyc) check("burst_timeout", 32'(bus.req), 32'd0);
    cycle();
    cycle();
  endtask

  task automatic check_quiet(input string pfx);
    @(negedge clk);
    check({pfx, "_state"},   32'(dbg_state),       32'(IDLE));
    check({pfx, "_ack"},     32'(bus.ack),         32'd0);
    check({pfx, "_done"},    32'(bus.done),        32'd0);
    check({pfx, "_rvalid"},  32'(bus.rvalid),      32'd0);
    check({pfx, "_wren"},    32'(bus.ram_wren),    32'd0);
    check({pfx, "_rdata"},   bus.rdata,            32'd0);
    check({pfx, "_ram_adr"}, 32'(bus.ram_address), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // All three request single-word reads; grant must rotate 0,1,2,0 with an
  // IDLE cycle between bursts.
  task automatic contention(input string tag);
    logic [NR-1:0] exp_seq [8];
    exp_seq = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    clear_stats();
    hold = '1;
    start_req(0, 1'b0, 9'h100, 4'd0);
    start_req(1, 1'b0, 9'h101, 4'd0);
    start_req(2, 1'b0, 9'h102, 4'd0);
    exp_q.push_back(32'h100); exp_q.push_back(32'h101);
    exp_q.push_back(32'h102); exp_q.push_back(32'h100);
    repeat (8) cycle();
    bus.req = '0;
    hold    = '0;
    cycle();
    cycle();
    for (int k = 0; k < 8; k++) check({tag, "_grant_seq"}, 32'(ack_log[k]), 32'(exp_seq[k]));
    check({tag, "_done0"}, 32'(done_cnt[0]), 32'd2);
    check({tag, "_done1"}, 32'(done_cnt[1]), 32'd1);
    check({tag, "_done2"}, 32'(done_cnt[2]), 32'd1);
    check({tag, "_rv0"},   32'(rv_cnt[0]),   32'd2);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    n_checks = 0; n_fail = 0; cyc = 0;
    pend_rv = '0; pend_rdata = '0; widx = 0;
    wr_words[0] = 32'hAAAA_0001; wr_words[1] = 32'hBBBB_0002;
    wr_words[2] = 32'hCCCC_0003; wr_words[3] = 32'hDDDD_0004;
    for (int k = 0; k < 512; k++) ref_mem[k] = pat(9'(k));
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.len = '0; bus.wdata = '0;
    clear_stats();
    reset = 1'b1;
    load_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    load_mem = 1'b0;

    // Reset state
    check_quiet("reset");

    // Round-robin from reset: requester 0 first
    contention("rr_after_reset");

    // Single 4-word read by requester 1
    clear_stats();
    start_req(1, 1'b0, 9'h1F0, 4'd3);
    exp_q.push_back(32'h1F0); exp_q.push_back(32'h1F1);
    exp_q.push_back(32'h1F2); exp_q.push_back(32'h1F3);
    run_until_idle(40);
    check("rd_ack_cnt",  32'(ack_cnt[1]),  32'd4);
    check("rd_rv_cnt",   32'(rv_cnt[1]),   32'd4);
    check("rd_done_cnt", 32'(done_cnt[1]), 32'd1);
    check("rd_done_4th", 32'(done_cyc[1] - first_ack_cyc[1]), 32'd3);

    // Write burst wrapping past 0x1FF
    clear_stats();
    widx = 0;
    bus.wdata[31:0] = wr_words[0];
    start_req(0, 1'b1, 9'h1FE, 4'd3);
    exp_q.push_back(32'h1FE); exp_q.push_back(32'h1FF);
    exp_q.push_back(32'h000); exp_q.push_back(32'h001);
    exp_wdata_q.push_back(32'hAAAA_0001); exp_wdata_q.push_back(32'hBBBB_0002);
    exp_wdata_q.push_back(32'hCCCC_0003); exp_wdata_q.push_back(32'hDDDD_0004);
    run_until_idle(40);
    check("wr_ack_cnt",  32'(ack_cnt[0]),  32'd4);
    check("wr_done_cnt", 32'(done_cnt[0]), 32'd1);
    check("wr_no_rv",    32'(rv_cnt[0]),   32'd0);

    // Read the wrapped words back
    clear_stats();
    start_req(0, 1'b0, 9'h1FE, 4'd3);
    exp_q.push_back(32'h1FE); exp_q.push_back(32'h1FF);
    exp_q.push_back(32'h000); exp_q.push_back(32'h001);
    run_until_idle(40);
    check("rb_rv_cnt",   32'(rv_cnt[0]),   32'd4);
    check("rb_done_cnt", 32'(done_cnt[0]), 32'd1);

    // Abort: 16-word read by requester 2, dropped after the 5th ack
    clear_stats();
    stop_after[2] = 5;
    start_req(2, 1'b0, 9'h080, 4'd15);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'h080 + 32'(k));
    run_until_idle(60);
    check("ab_ack_cnt",  32'(ack_cnt[2]),  32'd5);
    check("ab_rv_cnt",   32'(rv_cnt[2]),   32'd5);
    check("ab_done_cnt", 32'(done_cnt[2]), 32'd0);

    // Next request after the abort is served normally
    clear_stats();
    start_req(0, 1'b0, 9'h010, 4'd0);
    exp_q.push_back(32'h010);
    run_until_idle(20);
    check("post_ab_ack",  32'(ack_cnt[0]),  32'd1);
    check("post_ab_done", 32'(done_cnt[0]), 32'd1);
    check("post_ab_rv",   32'(rv_cnt[0]),   32'd1);

    // Reset in the middle of an 8-word read
    clear_stats();
    start_req(0, 1'b0, 9'h040, 4'd7);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h040 + 32'(k));
    n = 0;
    while (ack_cnt[0] < 2 && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) check("rst_wait_timeout", 32'(ack_cnt[0]), 32'd2);
    reset   = 1'b1;
    bus.req = '0;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    check("rst_ack_cnt",  32'(ack_cnt[0]),  32'd2);
    check_quiet("after_mid_reset");
    check("rst_done_cnt", 32'(done_cnt[0]), 32'd0);

    // Requester 0 wins again after the reset
    contention("rr_after_mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
